mips_ctrl_decoder: RTL and testbench
====================================

Name: mips_ctrl_decoder

Overview:
- Main control decoder for the single-issue MIPS datapath.
- Decodes the 6-bit primary opcode, plus the 6-bit funct field for R-type, into eight datapath control strobes and a 3-bit ALU operation class.
- Outputs are registered: one cycle of latency and a clean, glitch-free strobe set for the datapath stage that follows.

Parameters:
- NUM_SIGNALS, 8, width of the signals bus. Fixed at 8; other values are unsupported.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ins  input  6  instruction opcode field, instr[31:26].
- func  input  6  funct field, instr[5:0]; used only when ins==000000.
- signals  output  NUM_SIGNALS  registered control bus:
  - [0] RegDst
  - [1] Branch
  - [2] MemRead
  - [3] MemtoReg
  - [4] MemWrite
  - [5] ALUSrc
  - [6] RegWrite
  - [7] SignExt
- ALUOp  output  3  registered ALU class.

Behaviour:
- Reset: while rst_n==0, signals=8'h00 and ALUOp=3'b000, asynchronously. The first decode is registered on the first rising clk after rst_n deasserts.
- Latency: outputs reflect the ins/func sampled at the previous rising clk. There is no handshake; a decode is registered every cycle.
- ALUOp encoding:
  - 000 add
  - 001 sub
  - 010 R-type (ALU control uses func)
  - 011 and
  - 100 or
  - 101 slt
  - 110 sltu
  - 111 lui
- Decode table; every bit not listed is 0, and signals are given in hex, bit7..bit0:
  - R-type 000000, func != 001000: signals 41 (RegDst, RegWrite), ALUOp 010.
  - R-type 000000, func == 001000 (JR): signals 00, ALUOp 010.
  - LW 100011, LBU 100100, LHU 100101: EC (SignExt, RegWrite, ALUSrc, MemtoReg, MemRead), ALUOp 000.
  - SW 101011, SH 101001, SB 101000: B0 (SignExt, ALUSrc, MemWrite), ALUOp 000.
  - BEQ 000100, BNE 000101: 82 (SignExt, Branch), ALUOp 001.
  - ADDI 001000, ADDIU 001001: E0, ALUOp 000.
  - SLTI 001010: E0, ALUOp 101.
  - SLTIU 001011: E0, ALUOp 110.
  - ANDI 001100: 60 (zero-extended immediate), ALUOp 011.
  - ORI 001101: 60, ALUOp 100.
  - LUI 001111: 60, ALUOp 111.
  - J 000010, JAL 000011: 00, ALUOp 000. Jump target and link handling live outside this block.
  - Any other opcode, e.g. 100111: 00, ALUOp 000. No write or memory side effect is possible.
- func is ignored for every non-R-type opcode.
- X/Z on ins or func must not propagate: a case with a default arm produces the illegal-opcode result.
- Reset asserted mid-operation clears outputs immediately. No other state exists.

Optional Feature:
- Macro CTRL_ILLEGAL_DET_EN.
- Defined:
  - Adds output port illegal_op (1 bit), registered alongside signals and reset to 0.
  - illegal_op=1 for any opcode outside the table above.
  - illegal_op=1 for R-type with func not in {100000 ADD, 100001 ADDU, 100100 AND, 100111 NOR, 100101 OR, 101010 SLT, 101011 SLTU, 000000 SLL, 000010 SRL, 100010 SUB, 100011 SUBU, 001000 JR}.
  - For an illegal R-type func, signals are forced to 00.
- Undefined: no port; R-type with any func other than JR decodes as 41/010.

Test Plan:
- Reset: hold rst_n=0 with ins=100011 and toggle clk -> signals=00, ALUOp=000. Release rst_n -> after the next edge, signals=EC, ALUOp=000.
- R-type: ins=000000, func=100011 (SUBU) -> 41/010. Then func=001000 (JR) -> 00/010, one cycle after each change.
- Memory: ins=101011 -> B0/000; ins=100100 (LBU) -> EC/000.
- Branch and immediates:
  - ins=000100 -> 82/001
  - ins=001100 -> 60/011
  - ins=001101 -> 60/100
  - ins=001010 -> E0/101
  - ins=001011 -> E0/110
  - ins=001000 -> E0/000
  - ins=001111 -> 60/111
- Jumps and illegal: ins=000010 -> 00/000; ins=100111 -> 00/000; with CTRL_ILLEGAL_DET_EN, illegal_op=1 only for 100111.
- Latency/async reset: change ins between edges -> outputs unchanged until the next rising clk. Drop rst_n mid-cycle -> outputs are 00/000 before the next edge.

Source files
------------

// File: rtl/mips_ctrl_decoder_if.sv
// ============================================================================
// Module : mips_ctrl_decoder_if
// Brief  : Opcode/funct inputs and registered control outputs of the decoder.
//          CTRL_ILLEGAL_DET_EN adds the illegal_op output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mips_ctrl_decoder_if #(
   parameter int NUM_SIGNALS = 8
);
   logic [5:0]             ins;
   logic [5:0]             func;
   logic [NUM_SIGNALS-1:0] signals;
   logic [2:0]             ALUOp;
`ifdef CTRL_ILLEGAL_DET_EN
   logic                   illegal_op;

   modport master (output ins, output func, input signals, input ALUOp, input illegal_op);
   modport slave  (input ins, input func, output signals, output ALUOp, output illegal_op);
`else
   modport master (output ins, output func, input signals, input ALUOp);
   modport slave  (input ins, input func, output signals, output ALUOp);
`endif
endinterface

`default_nettype wire

// File: rtl/mips_ctrl_decoder.sv
// ============================================================================
// Module : mips_ctrl_decoder
// Brief  : Registered MIPS main control decoder (opcode/funct -> strobes+ALUOp).
//          Optional macro CTRL_ILLEGAL_DET_EN adds registered illegal_op.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_ctrl_decoder #(
   parameter int NUM_SIGNALS = 8
) (
   input  wire logic            clk,
   input  wire logic            rst_n,
   mips_ctrl_decoder_if.slave   bus
);
   // Opcodes
   localparam logic [5:0] c_OP_RTYPE = 6'b000000;
   localparam logic [5:0] c_OP_J     = 6'b000010;
   localparam logic [5:0] c_OP_JAL   = 6'b000011;
   localparam logic [5:0] c_OP_BEQ   = 6'b000100;
   localparam logic [5:0] c_OP_BNE   = 6'b000101;
   localparam logic [5:0] c_OP_ADDI  = 6'b001000;
   localparam logic [5:0] c_OP_ADDIU = 6'b001001;
   localparam logic [5:0] c_OP_SLTI  = 6'b001010;
   localparam logic [5:0] c_OP_SLTIU = 6'b001011;
   localparam logic [5:0] c_OP_ANDI  = 6'b001100;
   localparam logic [5:0] c_OP_ORI   = 6'b001101;
   localparam logic [5:0] c_OP_LUI   = 6'b001111;
   localparam logic [5:0] c_OP_LW    = 6'b100011;
   localparam logic [5:0] c_OP_LBU   = 6'b100100;
   localparam logic [5:0] c_OP_LHU   = 6'b100101;
   localparam logic [5:0] c_OP_SB    = 6'b101000;
   localparam logic [5:0] c_OP_SH    = 6'b101001;
   localparam logic [5:0] c_OP_SW    = 6'b101011;

   localparam logic [5:0] c_FN_JR    = 6'b001000;

   // ALU operation classes
   localparam logic [2:0] c_ALU_ADD  = 3'b000;
   localparam logic [2:0] c_ALU_SUB  = 3'b001;
   localparam logic [2:0] c_ALU_RTYP = 3'b010;
   localparam logic [2:0] c_ALU_AND  = 3'b011;
   localparam logic [2:0] c_ALU_OR   = 3'b100;
   localparam logic [2:0] c_ALU_SLT  = 3'b101;
   localparam logic [2:0] c_ALU_SLTU = 3'b110;
   localparam logic [2:0] c_ALU_LUI  = 3'b111;

   // Strobe sets, bit7..bit0 = SignExt RegWrite ALUSrc MemWrite MemtoReg MemRead Branch RegDst
   localparam logic [NUM_SIGNALS-1:0] c_SIG_NONE  = 8'h00;
   localparam logic [NUM_SIGNALS-1:0] c_SIG_RTYPE = 8'h41;
   localparam logic [NUM_SIGNALS-1:0] c_SIG_LOAD  = 8'hEC;
   localparam logic [NUM_SIGNALS-1:0] c_SIG_STORE = 8'hB0;
   localparam logic [NUM_SIGNALS-1:0] c_SIG_BR    = 8'h82;
   localparam logic [NUM_SIGNALS-1:0] c_SIG_IMMS  = 8'hE0;
   localparam logic [NUM_SIGNALS-1:0] c_SIG_IMMZ  = 8'h60;

   logic [NUM_SIGNALS-1:0] w_signals;
   logic [2:0]             w_aluop;
   logic                   w_illegal;

   logic [NUM_SIGNALS-1:0] r_signals;
   logic [2:0]             r_aluop;
   logic                   r_illegal;

   // Plain case with default arms: unknown/X selectors fall to the harmless no-op decode
   always_comb begin
      w_signals = c_SIG_NONE;
      w_aluop   = c_ALU_ADD;
      w_illegal = 1'b0;
      case (bus.ins)
         c_OP_RTYPE: begin
            w_aluop = c_ALU_RTYP;
            if (bus.func != c_FN_JR)
               w_signals = c_SIG_RTYPE;
`ifdef CTRL_ILLEGAL_DET_EN
            case (bus.func)
               6'b100000, 6'b100001, 6'b100100, 6'b100111,
               6'b100101, 6'b101010, 6'b101011, 6'b000000,
               6'b000010, 6'b100010, 6'b100011, 6'b001000: w_illegal = 1'b0;
               default: begin
                  w_illegal = 1'b1;
                  w_signals = c_SIG_NONE;
               end
            endcase
`endif
         end
         c_OP_LW, c_OP_LBU, c_OP_LHU: w_signals = c_SIG_LOAD;
         c_OP_SW, c_OP_SH, c_OP_SB:   w_signals = c_SIG_STORE;
         c_OP_BEQ, c_OP_BNE: begin
            w_signals = c_SIG_BR;
            w_aluop   = c_ALU_SUB;
         end
         c_OP_ADDI, c_OP_ADDIU:       w_signals = c_SIG_IMMS;
         c_OP_SLTI: begin
            w_signals = c_SIG_IMMS;
            w_aluop   = c_ALU_SLT;
         end
         c_OP_SLTIU: begin
            w_signals = c_SIG_IMMS;
            w_aluop   = c_ALU_SLTU;
         end
         c_OP_ANDI: begin
            w_signals = c_SIG_IMMZ;
            w_aluop   = c_ALU_AND;
         end
         c_OP_ORI: begin
            w_signals = c_SIG_IMMZ;
            w_aluop   = c_ALU_OR;
         end
         c_OP_LUI: begin
            w_signals = c_SIG_IMMZ;
            w_aluop   = c_ALU_LUI;
         end
         c_OP_J, c_OP_JAL:            w_signals = c_SIG_NONE;
         default:                     w_illegal = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_signals <= c_SIG_NONE;
         r_aluop   <= c_ALU_ADD;
         r_illegal <= 1'b0;
      end else begin
         r_signals <= w_signals;
         r_aluop   <= w_aluop;
         r_illegal <= w_illegal;
      end
   end

   assign bus.signals = r_signals;
   assign bus.ALUOp   = r_aluop;
`ifdef CTRL_ILLEGAL_DET_EN
   assign bus.illegal_op = r_illegal;
`else
   logic w_unused;
   assign w_unused = r_illegal;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mips_ctrl_decoder.sv
// ============================================================================
// Module : tb_mips_ctrl_decoder
// Brief  : Directed + random check of mips_ctrl_decoder against a table model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mips_ctrl_decoder;
   localparam int NUM_SIGNALS = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mips_ctrl_decoder_if #(.NUM_SIGNALS(NUM_SIGNALS)) bus ();
   mips_ctrl_decoder #(.NUM_SIGNALS(NUM_SIGNALS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] op_sig [64];
   logic [2:0] op_alu [64];
   bit         op_ok  [64];
   bit         fn_ok  [64];

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_op(input logic [5:0] op, input logic [7:0] s, input logic [2:0] a);
      op_sig[op] = s;
      op_alu[op] = a;
      op_ok[op]  = 1'b1;
   endtask

   // Reference: {illegal, signals, ALUOp} straight from the decode table
   function automatic logic [15:0] model(input logic [5:0] op, input logic [5:0] fn);
      logic [7:0] s;
      logic [2:0] a;
      logic       ill;
      if (op == 6'd0) begin
         a   = 3'b010;
         s   = (fn == 6'b001000) ? 8'h00 : 8'h41;
         ill = 1'b0;
`ifdef CTRL_ILLEGAL_DET_EN
         ill = !fn_ok[fn];
         if (ill) s = 8'h00;
`endif
      end else begin
         s   = op_sig[op];
         a   = op_alu[op];
         ill = 1'b0;
`ifdef CTRL_ILLEGAL_DET_EN
         ill = !op_ok[op];
`endif
      end
      return {4'b0, ill, s, a};
   endfunction

   function automatic logic [15:0] observed();
`ifdef CTRL_ILLEGAL_DET_EN
      return {4'b0, bus.illegal_op, bus.signals, bus.ALUOp};
`else
      return {4'b0, 1'b0, bus.signals, bus.ALUOp};
`endif
   endfunction

   task automatic apply(input logic [5:0] op, input logic [5:0] fn, input string tag);
      @(negedge clk);
      bus.ins  = op;
      bus.func = fn;
      @(posedge clk);
      #1;
      check(tag, observed(), model(op, fn));
   endtask

   initial begin
      logic [5:0] legal_fns [12];
      logic [5:0] op;
      logic [5:0] fn;

      for (int i = 0; i < 64; i++) begin
         op_sig[i] = 8'h00;
         op_alu[i] = 3'b000;
         op_ok[i]  = 1'b0;
         fn_ok[i]  = 1'b0;
      end
      op_ok[0] = 1'b1;
      set_op(6'b100011, 8'hEC, 3'b000);
      set_op(6'b100100, 8'hEC, 3'b000);
      set_op(6'b100101, 8'hEC, 3'b000);
      set_op(6'b101011, 8'hB0, 3'b000);
      set_op(6'b101001, 8'hB0, 3'b000);
      set_op(6'b101000, 8'hB0, 3'b000);
      set_op(6'b000100, 8'h82, 3'b001);
      set_op(6'b000101, 8'h82, 3'b001);
      set_op(6'b001000, 8'hE0, 3'b000);
      set_op(6'b001001, 8'hE0, 3'b000);
      set_op(6'b001010, 8'hE0, 3'b101);
      set_op(6'b001011, 8'hE0, 3'b110);
      set_op(6'b001100, 8'h60, 3'b011);
      set_op(6'b001101, 8'h60, 3'b100);
      set_op(6'b001111, 8'h60, 3'b111);
      set_op(6'b000010, 8'h00, 3'b000);
      set_op(6'b000011, 8'h00, 3'b000);
      legal_fns = '{6'b100000, 6'b100001, 6'b100100, 6'b100111, 6'b100101, 6'b101010,
                    6'b101011, 6'b000000, 6'b000010, 6'b100010, 6'b100011, 6'b001000};
      foreach (legal_fns[i]) fn_ok[legal_fns[i]] = 1'b1;

      // Reset held with a load opcode on the inputs
      rst_n    = 1'b0;
      bus.ins  = 6'b100011;
      bus.func = 6'b000000;
      repeat (3) @(posedge clk);
      #1;
      check("reset_hold", observed(), 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("first_decode_lw", observed(), model(6'b100011, 6'b000000));
      check("first_decode_lw_const", observed(), 16'h0760);

      apply(6'b000000, 6'b100011, "rtype_subu");
      apply(6'b000000, 6'b001000, "rtype_jr");
      apply(6'b101011, 6'b000000, "sw");
      apply(6'b100100, 6'b000000, "lbu");
      apply(6'b000100, 6'b000000, "beq");
      apply(6'b001100, 6'b000000, "andi");
      apply(6'b001101, 6'b000000, "ori");
      apply(6'b001010, 6'b000000, "slti");
      apply(6'b001011, 6'b000000, "sltiu");
      apply(6'b001000, 6'b111111, "addi");
      apply(6'b001111, 6'b000000, "lui");
      apply(6'b000010, 6'b000000, "j");
      apply(6'b100111, 6'b000000, "illegal_op");
      apply(6'b000000, 6'b111111, "rtype_badfunc");

      // Inputs changed between edges must not reach the outputs early
      apply(6'b100011, 6'b000000, "lat_lw");
      bus.ins = 6'b000100;
      #3;
      check("lat_hold", observed(), model(6'b100011, 6'b000000));
      @(posedge clk);
      #1;
      check("lat_update", observed(), model(6'b000100, 6'b000000));

      // Asynchronous reset mid-cycle
      apply(6'b001101, 6'b000000, "pre_async_ori");
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", observed(), 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      apply(6'b101000, 6'b000000, "post_async_sb");

      for (int i = 0; i < 400; i++) begin
         op = ($urandom_range(0, 3) == 0) ? 6'b000000 : 6'($urandom);
         fn = ($urandom_range(0, 7) == 0) ? 6'b001000 : 6'($urandom);
         apply(op, fn, "random");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
